systolic_array_ctrl: RTL and testbench
======================================

SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, giving the array dimension: N rows by N columns of weight-stationary PEs.
REQ-002 SHALL have parameter MaxVec, default 256, giving the maximum number of activation vectors per job.
REQ-003 SHALL have parameter CntW, default $clog2(MaxVec+1), giving the vector counter width.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all state on its rising edge.
REQ-006 res_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle job request.
REQ-008 num_vec  in  CntW  activation vectors in the job; sampled with start.
REQ-009 abort  in  1  synchronous job cancel.
REQ-010 w_valid / w_ready  in / out  1 / 1  weight-row stream handshake.
REQ-011 a_valid / a_ready  in / out  1 / 1  activation-vector stream handshake.
REQ-012 arr_w_en  out  1  weight shift enable to the array.
REQ-013 arr_l_b  out  1  weight latch strobe to all PEs.
REQ-014 arr_in_valid  out  N  per-row skewed valid strobes.
REQ-015 out_valid  out  1  result vector present at the array bottom.
REQ-016 busy / done  out / out  1 / 1  job active / single-cycle completion pulse.

Function
REQ-017 SHALL implement the states IDLE, LOAD_W, LATCH, STREAM and DRAIN, encoded one-hot or binary.
REQ-018 IDLE: start=1 with num_vec!=0 SHALL capture num_vec into a job register and enter LOAD_W on the next edge.
REQ-019 IDLE: start=1 with num_vec==0 SHALL stay in IDLE and pulse done on the next cycle.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 LOAD_W: w_ready=1; arr_w_en=w_valid&w_ready combinationally, the same cycle as the beat.
REQ-023 LOAD_W SHALL count beats 0..N-1; the Nth beat SHALL move to LATCH on the next edge; w_valid=0 stalls the count with no timeout.
REQ-024 LATCH SHALL last exactly one cycle with arr_l_b=1 and w_ready=0, then enter STREAM.
REQ-025 arr_l_b SHALL be 0 in every state other than LATCH.
REQ-026 STREAM: a_ready=1; beat=a_valid&a_ready.
REQ-027 arr_in_valid[0]=beat combinationally; arr_in_valid[r]=beat delayed r cycles through an N-1 stage shift register, for r=1..N-1.
REQ-028 out_valid SHALL equal beat delayed exactly 2N-1 cycles.
REQ-029 The skew pipeline SHALL keep shifting in every state, so trailing strobes complete during DRAIN.
REQ-030 STREAM SHALL count beats; the beat that makes the count equal num_vec SHALL move to DRAIN on the next edge; a_valid=0 stalls the count.
REQ-031 DRAIN: a_ready=0; SHALL remain in DRAIN for exactly 2N-1 cycles, then enter IDLE.
REQ-032 done SHALL be a registered 1 in the first IDLE cycle after DRAIN; the last out_valid coincides with the final DRAIN cycle.
REQ-033 The total count of out_valid pulses per job SHALL equal num_vec.
REQ-034 abort=1 in any state SHALL force IDLE on the next edge, clear all counters and the skew pipeline, and suppress done; abort has priority over start.
REQ-035 w_ready and a_ready SHALL never both be 1.
REQ-036 No ready SHALL be 1 in IDLE, LATCH or DRAIN.
REQ-037 Counters SHALL saturate and never wrap: num_vec=MaxVec SHALL be accepted.

Reset
REQ-038 res_n=0 SHALL asynchronously force IDLE and clear all counters, the job register and the skew pipeline.
REQ-039 During and after reset, all outputs SHALL be 0 until the first post-reset event.
REQ-040 Reset asserted mid-job SHALL discard the job with no done pulse.
REQ-041 After reset deassertion, the controller SHALL accept start on the first clock edge.

Verification
REQ-042 N=4, start with num_vec=3, w_valid and a_valid held 1:
  - 4 arr_w_en cycles, then 1 arr_l_b cycle;
  - arr_in_valid[3] first high 3 cycles after arr_in_valid[0];
  - 3 out_valid pulses, the first 7 cycles after the first beat;
  - done exactly 1 cycle after DRAIN.
REQ-043 N=4, w_valid toggling 1,0,1,0,...: LATCH entered only after the 4th accepted beat; arr_w_en high on exactly 4 cycles.
REQ-044 start with num_vec=0: done pulses on the next cycle, busy stays 0, no strobes.
REQ-045 abort asserted on the 2nd STREAM beat:
  - next cycle busy=0 and arr_in_valid=0;
  - no out_valid and no done follow;
  - a new start is accepted.
REQ-046 res_n pulsed low mid-DRAIN: all outputs are 0 immediately and no done follows; start while busy is ignored (num_vec not re-sampled).

Source files
------------

// File: rtl/systolic_array_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_ctrl_if
// Description : Handshake and array-control bundle between a job host and the
//               systolic array controller.
//               master : host side (drives start/num_vec/abort and the
//                        weight/activation valids).
//               slave  : controller side (drives readies, array strobes and
//                        job status).
//               Signals: start, num_vec[CntW], abort, w_valid/w_ready,
//                        a_valid/a_ready, arr_w_en, arr_l_b,
//                        arr_in_valid[N], out_valid, busy, done.
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_array_ctrl_if #(
  parameter int N      = 4,
  parameter int MaxVec = 256,
  parameter int CntW   = $clog2(MaxVec + 1)
);
  logic            start;
  logic [CntW-1:0] num_vec;
  logic            abort;
  logic            w_valid;
  logic            w_ready;
  logic            a_valid;
  logic            a_ready;
  logic            arr_w_en;
  logic            arr_l_b;
  logic [N-1:0]    arr_in_valid;
  logic            out_valid;
  logic            busy;
  logic            done;

  modport master (
    output start, num_vec, abort, w_valid, a_valid,
    input  w_ready, a_ready, arr_w_en, arr_l_b, arr_in_valid, out_valid,
           busy, done
  );

  modport slave (
    input  start, num_vec, abort, w_valid, a_valid,
    output w_ready, a_ready, arr_w_en, arr_l_b, arr_in_valid, out_valid,
           busy, done
  );
endinterface
`default_nettype wire

// File: rtl/systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_ctrl
// Description : Job sequencer for an N x N weight-stationary systolic array.
//               A job loads N weight rows, latches them into every PE, then
//               streams num_vec activation vectors with per-row skewed valid
//               strobes, and finally drains the array for 2N-1 cycles.
// Ports       : clk    - sole clock, rising edge
//               res_n  - asynchronous active-low reset
//               bus    - systolic_array_ctrl_if.slave (job control, weight and
//                        activation handshakes, array strobes, busy/done)
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array_ctrl #(
  parameter int N      = 4,                   // array dimension, N >= 2
  parameter int MaxVec = 256,                 // max activation vectors per job
  parameter int CntW   = $clog2(MaxVec + 1)   // vector counter width
) (
  input  wire                  clk,
  input  wire                  res_n,
  systolic_array_ctrl_if.slave bus
);

  // The skew line covers both the row skew (N-1 taps) and the full
  // propagation to the array bottom (2N-1 cycles), so one shift register
  // serves arr_in_valid and out_valid.
  localparam int SkewLen = 2 * N - 1;
  localparam int WCntW   = $clog2(N + 1);
  localparam int DCntW   = $clog2(SkewLen + 1);

  localparam logic [WCntW-1:0] WLast = WCntW'(N - 1);
  localparam logic [DCntW-1:0] DLast = DCntW'(SkewLen - 1);
  localparam logic [CntW-1:0]  VMax  = CntW'(MaxVec);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LATCH  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t             r_state;
  logic [WCntW-1:0]   r_wcnt;
  logic [CntW-1:0]    r_vcnt;
  logic [CntW-1:0]    r_job;
  logic [DCntW-1:0]   r_dcnt;
  logic [SkewLen-1:0] r_skew;   // r_skew[k] = activation beat delayed k+1
  logic               r_done;

  logic               w_w_beat;
  logic               w_a_beat;
  logic [CntW-1:0]    w_vcnt_inc;

  // Readies and status are pure decodes of the state register.
  assign bus.w_ready      = (r_state == S_LOAD_W);
  assign bus.a_ready      = (r_state == S_STREAM);
  assign w_w_beat         = bus.w_valid & bus.w_ready;
  assign w_a_beat         = bus.a_valid & bus.a_ready;
  assign bus.arr_w_en     = w_w_beat;
  assign bus.arr_l_b      = (r_state == S_LATCH);
  assign bus.arr_in_valid = {r_skew[N-2:0], w_a_beat};
  assign bus.out_valid    = r_skew[SkewLen-1];
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = r_done;

  assign w_vcnt_inc = r_vcnt + CntW'(1);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_vcnt  <= '0;
      r_job   <= '0;
      r_dcnt  <= '0;
      r_skew  <= '0;
      r_done  <= 1'b0;
    end else if (bus.abort) begin
      // Cancel wins over everything, including a start in the same cycle.
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_vcnt  <= '0;
      r_job   <= '0;
      r_dcnt  <= '0;
      r_skew  <= '0;
      r_done  <= 1'b0;
    end else begin
      // Skew line shifts in every state so trailing strobes finish in DRAIN.
      r_skew <= {r_skew[SkewLen-2:0], w_a_beat};
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.num_vec == '0) begin
              r_done <= 1'b1;            // empty job completes immediately
            end else begin
              // Oversized requests are clamped so the counter cannot wrap.
              r_job   <= (bus.num_vec > VMax) ? VMax : bus.num_vec;
              r_wcnt  <= '0;
              r_vcnt  <= '0;
              r_dcnt  <= '0;
              r_state <= S_LOAD_W;
            end
          end
        end

        S_LOAD_W: begin
          if (w_w_beat) begin
            if (r_wcnt == WLast) begin
              r_wcnt  <= '0;
              r_state <= S_LATCH;
            end else begin
              r_wcnt <= r_wcnt + WCntW'(1);
            end
          end
        end

        S_LATCH: begin
          r_state <= S_STREAM;
        end

        S_STREAM: begin
          if (w_a_beat) begin
            if (w_vcnt_inc == r_job) begin
              r_vcnt  <= '0;
              r_dcnt  <= '0;
              r_state <= S_DRAIN;
            end else if (r_vcnt != VMax) begin
              r_vcnt <= w_vcnt_inc;
            end
          end
        end

        S_DRAIN: begin
          if (r_dcnt == DLast) begin
            r_dcnt  <= '0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_dcnt <= r_dcnt + DCntW'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_systolic_array_ctrl
// Description : Self-checking bench for systolic_array_ctrl. Each job's
//               expected per-cycle output timeline is built from the job
//               rules (weight beats, latch, activation beats, drain, done)
//               and compared cycle by cycle, plus per-job pulse totals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_array_ctrl;
  localparam int N      = 4;
  localparam int MaxVec = 256;
  localparam int CntW   = $clog2(MaxVec + 1);
  localparam int OW     = N + 7;
  localparam int MAXC   = 1024;

  // Bit positions in the packed observation vector.
  localparam int P_DONE = 0;
  localparam int P_BUSY = 1;
  localparam int P_OV   = 2;
  localparam int P_INV  = 3;
  localparam int P_LB   = 3 + N;
  localparam int P_WEN  = 4 + N;
  localparam int P_AR   = 5 + N;
  localparam int P_WR   = 6 + N;

  logic clk   = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  systolic_array_ctrl_if #(.N(N), .MaxVec(MaxVec), .CntW(CntW)) bus ();

  systolic_array_ctrl #(.N(N), .MaxVec(MaxVec), .CntW(CntW)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  bit            wv   [MAXC];
  bit            av   [MAXC];
  logic [OW-1:0] expv [MAXC];
  int            errors = 0;
  int            checks = 0;

  function automatic logic [OW-1:0] observe();
    return {bus.w_ready, bus.a_ready, bus.arr_w_en, bus.arr_l_b,
            bus.arr_in_valid, bus.out_valid, bus.busy, bus.done};
  endfunction

  // Timeline model: cycle 0 carries start; returns the cycle done is due.
  task automatic build_model(input int nv, output int done_c);
    int c;
    int cnt;
    bit beat [MAXC];
    for (int i = 0; i < MAXC; i++) begin
      expv[i] = '0;
      beat[i] = 1'b0;
    end
    done_c = 1;
    if (nv != 0) begin
      c = 1;
      cnt = 0;
      while (cnt < N && c < MAXC / 2) begin         // weight load
        expv[c][P_WR]   = 1'b1;
        expv[c][P_BUSY] = 1'b1;
        if (wv[c]) begin
          expv[c][P_WEN] = 1'b1;
          cnt++;
        end
        c++;
      end
      expv[c][P_LB]   = 1'b1;                       // one latch cycle
      expv[c][P_BUSY] = 1'b1;
      c++;
      cnt = 0;
      while (cnt < nv && c < MAXC / 2) begin        // activation stream
        expv[c][P_AR]   = 1'b1;
        expv[c][P_BUSY] = 1'b1;
        if (av[c]) begin
          beat[c] = 1'b1;
          cnt++;
        end
        c++;
      end
      for (int d = 0; d < 2 * N - 1; d++) begin     // drain
        expv[c][P_BUSY] = 1'b1;
        c++;
      end
      done_c = c;
    end
    expv[done_c][P_DONE] = 1'b1;
    for (int b = 0; b < MAXC / 2; b++) begin
      if (beat[b]) begin
        for (int r = 0; r < N; r++) expv[b + r][P_INV + r] = 1'b1;
        expv[b + 2 * N - 1][P_OV] = 1'b1;
      end
    end
  endtask

  // wmode/amode: 0 = valid held high, 1 = toggling 1,0,1,0 from cycle 1,
  // 2 = random (75% high). abort_at / reset_at < 0 means not used.
  task automatic run_job(input string tag, input int nv, input int wmode,
                         input int amode, input int abort_at,
                         input int reset_at);
    int            done_c;
    int            len;
    int            ovs;
    int            wens;
    int            exp_ov;
    bit            trunc;
    logic [OW-1:0] obs;
    for (int c = 0; c < MAXC; c++) begin
      wv[c] = (wmode == 0) ? 1'b1 : (wmode == 1) ? (c % 2 == 1)
                                  : ($urandom_range(0, 3) != 0);
      av[c] = (amode == 0) ? 1'b1 : (amode == 1) ? (c % 2 == 1)
                                  : ($urandom_range(0, 3) != 0);
    end
    build_model(nv, done_c);
    len    = done_c + 3;
    exp_ov = nv;
    trunc  = 1'b0;
    if (abort_at >= 0) begin
      for (int c = abort_at + 1; c < MAXC; c++) expv[c] = '0;
      len    = abort_at + 5;
      exp_ov = 0;
      trunc  = 1'b1;
    end
    if (reset_at >= 0) begin
      for (int c = reset_at; c < MAXC; c++) expv[c] = '0;
      len    = reset_at + 6;
      exp_ov = 0;
      trunc  = 1'b1;
    end
    ovs  = 0;
    wens = 0;
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      bus.start   = (c == 0);
      bus.num_vec = (c == 0) ? CntW'(nv) : CntW'($urandom_range(0, MaxVec));
      // Stray starts while busy must be ignored.
      if (c > 0 && expv[c][P_BUSY] && $urandom_range(0, 3) == 0)
        bus.start = 1'b1;
      bus.abort   = (c == abort_at);
      if (reset_at >= 0) res_n = !(c >= reset_at && c < reset_at + 2);
      bus.w_valid = wv[c];
      bus.a_valid = av[c];
      @(negedge clk);
      obs  = observe();
      ovs  = ovs + int'(obs[P_OV]);
      wens = wens + int'(obs[P_WEN]);
      checks++;
      assert (obs === expv[c]) else begin
        errors++;
        $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, c, obs, expv[c]);
      end
    end
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.w_valid = 1'b0;
    bus.a_valid = 1'b0;
    checks++;
    assert (ovs === exp_ov) else begin
      errors++;
      $error("FAIL %s out_valid_count observed=%0d expected=%0d", tag, ovs, exp_ov);
    end
    if (!trunc && nv != 0) begin
      checks++;
      assert (wens === N) else begin
        errors++;
        $error("FAIL %s arr_w_en_count observed=%0d expected=%0d", tag, wens, N);
      end
    end
  endtask

  initial begin
    logic [OW-1:0] obs;
    bus.start   = 1'b0;
    bus.num_vec = '0;
    bus.abort   = 1'b0;
    bus.w_valid = 1'b0;
    bus.a_valid = 1'b0;
    res_n       = 1'b0;
    #12;
    obs = observe();
    checks++;
    assert (obs === '0) else begin
      errors++;
      $error("FAIL reset_state observed=%b expected=%b", obs, {OW{1'b0}});
    end
    @(posedge clk);
    #1;
    res_n = 1'b1;

    run_job("basic3",      3, 0, 0, -1, -1);
    run_job("wtoggle",     2, 1, 0, -1, -1);
    run_job("zero_vec",    0, 0, 0, -1, -1);
    run_job("abort_beat2", 5, 0, 0,  7, -1);
    run_job("after_abort", 2, 0, 2, -1, -1);
    run_job("rst_drain",   3, 0, 0, -1, 11);
    run_job("after_rst",   1, 2, 2, -1, -1);
    for (int j = 0; j < 6; j++)
      run_job("rand", int'($urandom_range(1, 12)), 2, 2, -1, -1);
    run_job("rand_abort", int'($urandom_range(1, 8)), 2, 2,
            int'($urandom_range(2, 12)), -1);
    run_job("max_vec", MaxVec, 0, 0, -1, -1);
    run_job("final", 2, 2, 2, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
